lgdst_ts_deser: RTL and testbench
=================================

Name: lgdst_ts_deser

Overview:
Receive-side counterpart of the SPI-to-serial-TS glue. Oversamples a serial MPEG-TS link (ts_clk/ts_valid/ts_sync/ts_d0) on the system clock and deserialises it into bytes. Locks onto 188-byte packets and delivers them on a valid/ready byte stream with SOP/EOP markers. Sits on the host/baseband side of the link, feeding the packet buffer, with error and overflow status for firmware.

Parameters:
PKT_LEN, 188, bytes per TS packet (>=2)
SYNC_BYTE, 8'h47, required first byte of every packet
SAMPLE_FALL, 1, 1 = sample ts_d0 on ts_clk falling edge (link changes data on rising edge); 0 = rising edge
MSB_FIRST, 1, 1 = first serial bit is byte bit 7

Ports:
clk  input  1  system clock; must be >= 4x ts_clk frequency
reset  input  1  synchronous, active-high reset
ts_clk  input  1  serial TS bit clock, asynchronous to clk
ts_valid  input  1  bit qualifier, active high
ts_sync  input  1  high during the first bit of a packet
ts_d0  input  1  serial data
out_data  output  8  assembled byte
out_sop  output  1  out_data is packet byte 0
out_eop  output  1  out_data is packet byte PKT_LEN-1
out_valid  output  1  byte available
out_ready  input  1  consumer accepts when out_valid & out_ready
locked  output  1  at least one full good packet since last error
sync_err  output  1  one-clk pulse: bad sync byte or early ts_sync
ovf  output  1  one-clk pulse: byte dropped, FIFO full
pkt_cnt  output  16  good packets delivered, wraps at 16'hFFFF
err_cnt  output  8  sync_err + ovf events, saturates at 8'hFF

Behaviour:
- Reset (reset=1 at a clk edge): all outputs 0, FIFO emptied, FSM=HUNT, counters 0. A mid-packet reset discards the partial byte/packet with no error pulse.
- Input path: ts_clk, ts_valid, ts_sync, ts_d0 each pass through a 2-flop synchroniser. An edge detector on synced ts_clk produces a one-clk sample strobe on the selected edge. Only strobes with synced ts_valid=1 are taken; ts_valid low pauses assembly without losing bit/byte position.
- Latency: out_valid rises 4 clk edges after the edge at which synchroniser stage 1 first captures the sampling ts_clk edge of bit 7 (FIFO empty).
- FSM HUNT: ignore bits until a taken sample has ts_sync=1. That bit is bit 0 of byte 0; bit_cnt=1, byte_cnt=0, go to DATA.
- FSM DATA: shift each taken bit (MSB_FIRST order); bit_cnt wraps 7->0 on byte completion, byte_cnt increments.
  - Byte 0 completes != SYNC_BYTE: not written; sync_err pulse; locked=0; go to HUNT.
  - ts_sync=1 on a taken sample with (bit_cnt,byte_cnt) != (0,0): sync_err pulse; locked=0; partial packet abandoned (no EOP emitted); this bit restarts as bit 0 of byte 0; stay in DATA.
  - ts_sync=1 exactly at (0,0): normal, no error.
  - Byte PKT_LEN-1 completes: written with eop=1; pkt_cnt++ and locked=1 when written; go to HUNT.
- Output FIFO: 2 entries of {sop,eop,data[7:0]}, first-word fall-through; out_* driven from the head entry. Write and read in the same clk are allowed when not empty.
  - Full at byte completion: byte dropped; ovf pulse; locked=0; go to HUNT; already-queued bytes stay and drain (consumer sees SOP without EOP).
- sync_err and ovf in the same clk: err_cnt += 2, saturating.
- out_data/out_sop/out_eop are held stable while out_valid=1 and out_ready=0.

Decomposition:
- Package lgdst_ts_pkg: TS_PKT_LEN=188, TS_SYNC_BYTE=8'h47, FSM state enum {HUNT, DATA}, FIFO entry struct {sop, eop, data}.
- Sub-module lgdst_ts_fifo2: 2-deep FWFT FIFO with full/empty flags.
- Synchroniser, edge detect, shifter, FSM and counters live in the top module.

Test Plan:
- Send one packet 47 00 01 .. BA (188 bytes) with ts_clk = clk/8, out_ready=1 -> 188 bytes out in order; SOP on byte 0 (0x47), EOP on byte 187; pkt_cnt=1; locked=1; latency 4 clk.
- Send a packet whose first byte is 0x46 -> no bytes out; one sync_err pulse; err_cnt=1; locked=0; a following good packet is fully received.
- Assert ts_sync at byte 100 bit 3, then send a full good packet -> one sync_err; the first 100 bytes appear without EOP; the new packet is delivered intact; pkt_cnt increments by 1.
- Hold out_ready=0 from byte 5 -> bytes 5,6 queued; byte 7 drops with an ovf pulse; FSM returns to HUNT; releasing out_ready drains bytes 5,6; the next packet is good.
- ts_valid low for 50 clk between every byte (SPI burst gaps) -> packet delivered intact and identical to the no-gap case.
- Assert reset at byte 60, then send a full packet -> all outputs 0 the cycle after reset; no error pulses; next packet delivered; pkt_cnt=1.

Source files
------------

// File: rtl/lgdst_ts_pkg.sv
// Shared constants and types for the serial MPEG-TS receive path.
package lgdst_ts_pkg;

  localparam int unsigned TS_PKT_LEN   = 188;
  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;

  typedef enum logic {HUNT, DATA} ts_state_e;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } ts_entry_t;

endpackage

// File: rtl/lgdst_ts_fifo2.sv
// Two-entry first-word-fall-through FIFO for assembled TS bytes.
module lgdst_ts_fifo2
  import lgdst_ts_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      wr_en_i,
  input  ts_entry_t wr_data_i,
  input  logic      rd_en_i,
  output ts_entry_t rd_data_o,
  output logic      full_o,
  output logic      empty_o
);

  ts_entry_t  mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] cnt_q;
  logic       wr_ok, rd_ok;

  always_comb begin
    full_o    = (cnt_q == 2'd2);
    empty_o   = (cnt_q == 2'd0);
    wr_ok     = wr_en_i & ~full_o;
    rd_ok     = rd_en_i & ~empty_o;
    rd_data_o = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (wr_ok) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (rd_ok) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, wr_ok} - {1'b0, rd_ok};
    end
  end

endmodule

// File: rtl/lgdst_ts_deser.sv
// Oversampling serial MPEG-TS deserialiser: locks to packets and emits a
// valid/ready byte stream with SOP/EOP plus error/overflow status.
module lgdst_ts_deser
  import lgdst_ts_pkg::*;
#(
  parameter int unsigned PKT_LEN     = TS_PKT_LEN,
  parameter logic [7:0]  SYNC_BYTE   = TS_SYNC_BYTE,
  parameter logic        SAMPLE_FALL = 1'b1,
  parameter logic        MSB_FIRST   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ts_clk,
  input  logic        ts_valid,
  input  logic        ts_sync,
  input  logic        ts_d0,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        locked,
  output logic        sync_err,
  output logic        ovf,
  output logic [15:0] pkt_cnt,
  output logic [7:0]  err_cnt
);

  localparam int unsigned   BW        = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(PKT_LEN - 1);

  logic [3:0]    in_s1_q, in_s2_q;  // {ts_clk, ts_valid, ts_sync, ts_d0}
  logic          clk_s3_q;
  logic          strobe, take;
  logic          tka_q, syna_q, bita_q, tkb_q, synb_q, bitb_q;
  ts_state_e     state_q, state_d;
  logic [7:0]    shift_q, shift_d, shifted;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic          locked_q, locked_d, sync_err_q, ovf_q;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [8:0]    err_sum;
  logic          hunt_hit, early_sync, err_sync, err_ovf, good_pkt, to_hunt;
  logic          wr_en, fifo_full, fifo_empty;
  ts_entry_t     wr_entry, head;

  always_comb begin
    strobe = SAMPLE_FALL ? (clk_s3_q & ~in_s2_q[3]) : (~clk_s3_q & in_s2_q[3]);
    take   = strobe & in_s2_q[2];
  end

  // Two sample-pipeline stages after the edge detector fix the 4-clk
  // ts_clk-edge-to-out_valid latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_s1_q  <= '0;
      in_s2_q  <= '0;
      clk_s3_q <= 1'b0;
      tka_q    <= 1'b0;
      syna_q   <= 1'b0;
      bita_q   <= 1'b0;
      tkb_q    <= 1'b0;
      synb_q   <= 1'b0;
      bitb_q   <= 1'b0;
    end else begin
      in_s1_q  <= {ts_clk, ts_valid, ts_sync, ts_d0};
      in_s2_q  <= in_s1_q;
      clk_s3_q <= in_s2_q[3];
      tka_q    <= take;
      syna_q   <= in_s2_q[1];
      bita_q   <= in_s2_q[0];
      tkb_q    <= tka_q;
      synb_q   <= syna_q;
      bitb_q   <= bita_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HUNT;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
      ovf_q      <= 1'b0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      locked_q   <= locked_d;
      sync_err_q <= err_sync;
      ovf_q      <= err_ovf;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (hunt_hit) state_d = DATA;
      DATA:    if (to_hunt)  state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    hunt_hit   = tkb_q & synb_q & (state_q == HUNT);
    early_sync = tkb_q & synb_q & (state_q == DATA) &
                 ((bit_cnt_q != '0) | (byte_cnt_q != '0));
    shifted    = MSB_FIRST ? {shift_q[6:0], bitb_q} : {bitb_q, shift_q[7:1]};
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    err_sync   = 1'b0;
    err_ovf    = 1'b0;
    good_pkt   = 1'b0;
    to_hunt    = 1'b0;
    wr_en      = 1'b0;
    if (hunt_hit | early_sync) begin
      // A sync bit always restarts framing as bit 0 of byte 0.
      shift_d    = shifted;
      bit_cnt_d  = 3'd1;
      byte_cnt_d = '0;
      err_sync   = early_sync;
    end else if (tkb_q & (state_q == DATA)) begin
      shift_d = shifted;
      if (bit_cnt_q != 3'd7) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end else begin
        bit_cnt_d = '0;
        if ((byte_cnt_q == '0) && (shifted != SYNC_BYTE)) begin
          err_sync = 1'b1;
          to_hunt  = 1'b1;
        end else if (fifo_full) begin
          err_ovf = 1'b1;
          to_hunt = 1'b1;
        end else begin
          wr_en = 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            good_pkt = 1'b1;
            to_hunt  = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + BW'(1);
          end
        end
      end
    end

    wr_entry.sop  = (byte_cnt_q == '0);
    wr_entry.eop  = (byte_cnt_q == LAST_BYTE);
    wr_entry.data = shifted;

    locked_d = locked_q;
    if (err_sync | err_ovf) locked_d = 1'b0;
    else if (good_pkt)      locked_d = 1'b1;
    pkt_cnt_d = good_pkt ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
    err_sum   = {1'b0, err_cnt_q} + {8'd0, err_sync} + {8'd0, err_ovf};
    err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  lgdst_ts_fifo2 u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_entry),
    .rd_en_i   (out_ready),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    out_data  = head.data;
    out_sop   = head.sop;
    out_eop   = head.eop;
    out_valid = ~fifo_empty;
    locked    = locked_q;
    sync_err  = sync_err_q;
    ovf       = ovf_q;
    pkt_cnt   = pkt_cnt_q;
    err_cnt   = err_cnt_q;
  end

endmodule

// File: tb/tb_lgdst_ts_deser.sv
// Directed/randomised bench for lgdst_ts_deser with a packet-level scoreboard.
`timescale 1ns/1ps
module tb_lgdst_ts_deser;

  localparam int PKT = 188;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ts_clk = 1'b0, ts_valid = 1'b0, ts_sync = 1'b0, ts_d0 = 1'b0;
  logic [7:0]  out_data;
  logic        out_sop, out_eop, out_valid;
  logic        out_ready = 1'b1;
  logic        locked, sync_err, ovf;
  logic [15:0] pkt_cnt;
  logic [7:0]  err_cnt;

  lgdst_ts_deser #(.PKT_LEN(PKT), .SYNC_BYTE(8'h47), .SAMPLE_FALL(1'b1), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .ts_clk(ts_clk), .ts_valid(ts_valid), .ts_sync(ts_sync),
    .ts_d0(ts_d0), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_valid(out_valid), .out_ready(out_ready), .locked(locked), .sync_err(sync_err),
    .ovf(ovf), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  int          n_sync = 0, n_ovf = 0;
  int          exp_sync = 0, exp_ovf = 0, exp_pkt = 0, exp_err = 0;
  int unsigned thalf = 40;
  logic [9:0]  exp_q [$];
  logic [7:0]  pkt [PKT];
  logic        probe = 1'b0;
  logic        hold_prev = 1'b0;
  logic [9:0]  hold_val = '0;
  event        lat_ev;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consumer-side scoreboard and status pulse counting.
  always @(negedge clk) begin
    logic [9:0] e;
    if (!reset) begin
      if (sync_err) n_sync++;
      if (ovf) n_ovf++;
      if (hold_prev && out_valid) chk("hold_stable", {out_sop, out_eop, out_data}, hold_val);
      hold_prev = out_valid && !out_ready;
      hold_val  = {out_sop, out_eop, out_data};
      if (out_valid && out_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL extra_byte observed %0h expected none", {out_sop, out_eop, out_data});
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("byte", {out_sop, out_eop, out_data}, e);
        end
      end
    end
  end

  // Latency: out_valid must rise on the 4th clk edge after stage 1 sees the edge.
  initial begin
    @(lat_ev);
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 chk("lat_edge3", out_valid, 1'b0);
    @(posedge clk);
    #1 chk("lat_edge4", out_valid, 1'b1);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic d, input logic s, input logic v, input logic fire);
    ts_d0 = d; ts_sync = s; ts_valid = v; ts_clk = 1'b1;
    #(thalf);
    ts_clk = 1'b0;
    if (fire) -> lat_ev;
    #(thalf);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input logic first, input logic fire);
    for (int i = 7; i > 7 - nbits; i--)
      send_bit(b[i], first && (i == 7), 1'b1, fire && (i == 0));
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_range(input int from, input int to, input int gap);
    for (int i = from; i < to; i++) begin
      send_bits(pkt[i], 8, i == 0, probe && (i == 0));
      if (gap > 0) send_idle(gap);
    end
  endtask

  task automatic make_pkt(input logic ramp);
    pkt[0] = 8'h47;
    for (int i = 1; i < PKT; i++) pkt[i] = ramp ? 8'(i - 1) : 8'($urandom);
  endtask

  // Expected output: first n bytes of the packet; EOP only if the whole packet arrives.
  task automatic expect_bytes(input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == 0), (n == PKT) && (i == PKT - 1), pkt[i]});
  endtask

  task automatic wait_q(input int target, input string tag);
    int k = 0;
    while (exp_q.size() > target && k < 5000) begin
      @(posedge clk);
      k++;
    end
    chk(tag, exp_q.size(), target);
  endtask

  task automatic chk_status(input string tag, input logic exp_lock);
    chk({tag, "_pkt_cnt"}, pkt_cnt, exp_pkt);
    chk({tag, "_err_cnt"}, err_cnt, exp_err);
    chk({tag, "_locked"}, locked, exp_lock);
    chk({tag, "_n_sync"}, n_sync, exp_sync);
    chk({tag, "_n_ovf"}, n_ovf, exp_ovf);
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1 chk("reset_outs", {out_valid, out_sop, out_eop, out_data, locked, sync_err, ovf, pkt_cnt, err_cnt}, 64'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #3;

    // Clean ramp packet at ts_clk = clk/8
    make_pkt(1'b1);
    expect_bytes(PKT);
    probe = 1'b1;
    send_range(0, PKT, 0);
    probe = 1'b0;
    send_idle(4);
    wait_q(0, "t1_drain");
    exp_pkt = 1;
    chk_status("t1", 1'b1);

    // Bad first byte, then a good random packet
    thalf = 25;
    send_bits(8'h46, 8, 1'b1, 1'b0);
    send_bits(8'($urandom), 8, 1'b0, 1'b0);
    send_bits(8'($urandom), 8, 1'b0, 1'b0);
    send_idle(4);
    exp_sync++; exp_err++;
    chk_status("t2_bad", 1'b0);
    make_pkt(1'b0);
    expect_bytes(PKT);
    send_range(0, PKT, 0);
    send_idle(4);
    wait_q(0, "t2_drain");
    exp_pkt++;
    chk_status("t2_good", 1'b1);

    // Early ts_sync at byte 100 bit 3 restarts into a new good packet
    make_pkt(1'b0);
    expect_bytes(100);
    send_range(0, 100, 0);
    send_bits(pkt[100], 4, 1'b0, 1'b0);
    make_pkt(1'b0);
    expect_bytes(PKT);
    send_range(0, PKT, 0);
    send_idle(4);
    wait_q(0, "t3_drain");
    exp_sync++; exp_err++; exp_pkt++;
    chk_status("t3", 1'b1);

    // Consumer stalls from byte 5: bytes 5,6 queue, byte 7 overflows
    make_pkt(1'b0);
    expect_bytes(7);
    send_range(0, 5, 0);
    wait_q(2, "t4_pre_stall");
    @(posedge clk);
    #1 out_ready = 1'b0;
    send_range(5, 10, 0);
    send_idle(4);
    exp_ovf++; exp_err++;
    chk_status("t4_ovf", 1'b0);
    chk("t4_queued", exp_q.size(), 2);
    chk("t4_head", {out_valid, out_sop, out_eop, out_data}, {1'b1, 1'b0, 1'b0, pkt[5]});
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_q(0, "t4_drain");
    #2;

    // Ramp packet with ~50-clk ts_valid gaps between bytes
    make_pkt(1'b1);
    expect_bytes(PKT);
    send_range(0, PKT, 10);
    send_idle(4);
    wait_q(0, "t5_drain");
    exp_pkt++;
    chk_status("t5", 1'b1);

    // Mid-packet reset at byte 60
    make_pkt(1'b0);
    expect_bytes(60);
    send_range(0, 60, 0);
    send_bits(pkt[60], 3, 1'b0, 1'b0);
    wait_q(0, "t6_pre_drain");
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 chk("t6_reset_outs", {out_valid, out_sop, out_eop, out_data, locked, sync_err, ovf, pkt_cnt, err_cnt}, 64'd0);
    reset = 1'b0;
    exp_pkt = 0; exp_err = 0;
    #2;
    make_pkt(1'b0);
    expect_bytes(PKT);
    send_range(0, PKT, 0);
    send_idle(4);
    wait_q(0, "t6_drain");
    exp_pkt = 1;
    chk_status("t6", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
